// File: rtl/cpu.sv
// cpu: single-issue, non-pipelined 64-bit CPU running a fixed Fibonacci program from an internal ROM.
// OUT spends a second stall cycle, so every strobe is a separate one-cycle pulse.
module cpu #(
   parameter int ROM_DEPTH = 64
) (
   input  logic        clk,
   input  logic        rst,
   output logic [63:0] dbg_pc,
   output logic        io_write,
   output logic [63:0] io_data
);

   localparam int          AW        = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
   localparam logic [31:0] HALT_WORD = 32'hF000_0000;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0, OP_LI  = 4'h1, OP_ADD = 4'h2, OP_SUB  = 4'h3,
      OP_AND  = 4'h4, OP_OR  = 4'h5, OP_XOR = 4'h6, OP_ADDI = 4'h7,
      OP_BEQ  = 4'h8, OP_BNE = 4'h9, OP_JMP = 4'hA, OP_OUT  = 4'hB,
      OP_HALT = 4'hF
   } op_e;

   logic [AW-1:0] pc_q, pc_d;
   logic          halt_q, halt_d;
   logic          stall_q, stall_d;
   logic          io_write_q, io_write_d;
   logic [63:0]   io_data_q, io_data_d;
   logic [63:0]   rf_q [16];

   logic                rf_we_d;
   logic [3:0]          rf_wa_d;
   logic [63:0]         rf_wd_d;
   logic [31:0]         instr;
   op_e                 op;
   logic [3:0]          rd, rs1_a, rs2_a;
   logic [15:0]         imm;
   logic signed [63:0]  imm_sx, rs1_v, rs2_v;
   logic [AW-1:0]       pc_inc, br_tgt, jmp_tgt;

   function automatic logic [31:0] rom_word(input logic [AW-1:0] addr);
      logic [31:0] w;
      case (32'(addr))
         32'd0:   w = 32'h1000_0000;
         32'd1:   w = 32'h1200_0001;
         32'd2:   w = 32'h1300_000A;
         32'd3:   w = 32'hB010_0000;
         32'd4:   w = 32'h2412_0000;
         32'd5:   w = 32'h2120_0000;
         32'd6:   w = 32'h2240_0000;
         32'd7:   w = 32'h7330_FFFF;
         32'd8:   w = 32'h9030_FFFB;
         default: w = HALT_WORD;
      endcase
      return w;
   endfunction

   // Reduce a signed word index into [0, ROM_DEPTH) so negative branch offsets wrap correctly.
   function automatic logic [AW-1:0] wrap(input logic signed [31:0] v);
      logic signed [31:0] r;
      r = v % ROM_DEPTH;
      if (r < 0) r = r + ROM_DEPTH;
      return r[AW-1:0];
   endfunction

   assign instr   = rom_word(pc_q);
   assign op      = op_e'(instr[31:28]);
   assign rd      = instr[27:24];
   assign rs1_a   = instr[23:20];
   assign rs2_a   = instr[19:16];
   assign imm     = instr[15:0];
   assign imm_sx  = {{48{imm[15]}}, imm};
   assign rs1_v   = (rs1_a == 4'd0) ? 64'sd0 : rf_q[rs1_a];
   assign rs2_v   = (rs2_a == 4'd0) ? 64'sd0 : rf_q[rs2_a];
   assign pc_inc  = wrap(signed'(32'(pc_q)) + 32'sd1);
   assign br_tgt  = wrap(signed'(32'(pc_q)) + signed'({{16{imm[15]}}, imm}));
   assign jmp_tgt = wrap(signed'({16'b0, imm}));

   always_comb begin
      pc_d       = pc_q;
      halt_d     = halt_q;
      stall_d    = stall_q;
      io_write_d = 1'b0;
      io_data_d  = io_data_q;
      rf_we_d    = 1'b0;
      rf_wa_d    = rd;
      rf_wd_d    = '0;
      if (!halt_q) begin
         if (stall_q) begin
            stall_d = 1'b0;
            pc_d    = pc_inc;
         end else begin
            pc_d = pc_inc;
            case (op)
               OP_LI:   begin rf_we_d = 1'b1; rf_wd_d = imm_sx;          end
               OP_ADD:  begin rf_we_d = 1'b1; rf_wd_d = rs1_v + rs2_v;   end
               OP_SUB:  begin rf_we_d = 1'b1; rf_wd_d = rs1_v - rs2_v;   end
               OP_AND:  begin rf_we_d = 1'b1; rf_wd_d = rs1_v & rs2_v;   end
               OP_OR:   begin rf_we_d = 1'b1; rf_wd_d = rs1_v | rs2_v;   end
               OP_XOR:  begin rf_we_d = 1'b1; rf_wd_d = rs1_v ^ rs2_v;   end
               OP_ADDI: begin rf_we_d = 1'b1; rf_wd_d = rs1_v + imm_sx;  end
               OP_BEQ:  if (rs1_v == rs2_v) pc_d = br_tgt;
               OP_BNE:  if (rs1_v != rs2_v) pc_d = br_tgt;
               OP_JMP:  pc_d = jmp_tgt;
               OP_OUT: begin
                  io_data_d  = rs1_v;
                  io_write_d = 1'b1;
                  stall_d    = 1'b1;
                  pc_d       = pc_q;
               end
               OP_HALT: begin
                  halt_d = 1'b1;
                  pc_d   = pc_q;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q       <= '0;
         halt_q     <= 1'b0;
         stall_q    <= 1'b0;
         io_write_q <= 1'b0;
         io_data_q  <= '0;
      end else begin
         pc_q       <= pc_d;
         halt_q     <= halt_d;
         stall_q    <= stall_d;
         io_write_q <= io_write_d;
         io_data_q  <= io_data_d;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) rf_q[i] <= '0;
      end else if (rf_we_d && (rf_wa_d != 4'd0)) begin
         rf_q[rf_wa_d] <= rf_wd_d;
      end
   end

   assign dbg_pc   = 64'(pc_q);
   assign io_write = io_write_q;
   assign io_data  = io_data_q;

endmodule

// File: tb/tb_cpu.sv
// Scoreboard bench for cpu: an instruction-level interpreter predicts the per-cycle pc trace and OUT
// values; a monitor compares the DUT every cycle while runs are cut short by randomly timed async resets.
module tb_cpu;

   localparam int ROM_DEPTH = 64;

   logic        clk;
   logic        rst;
   logic [63:0] dbg_pc;
   logic        io_write;
   logic [63:0] io_data;

   int          vectors     = 0;
   int          miscompares = 0;
   logic        mon_en      = 1'b0;
   logic [63:0] exp_pc  [$];
   logic [63:0] exp_out [$];
   logic [31:0] prog [10] = '{32'h1000_0000, 32'h1200_0001, 32'h1300_000A, 32'hB010_0000,
                              32'h2412_0000, 32'h2120_0000, 32'h2240_0000, 32'h7330_FFFF,
                              32'h9030_FFFB, 32'hF000_0000};

   cpu #(.ROM_DEPTH(ROM_DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .dbg_pc   (dbg_pc),
      .io_write (io_write),
      .io_data  (io_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] fetch(input int pc);
      if (pc < 10) return prog[pc];
      return 32'hF000_0000;
   endfunction

   function automatic int wrap(input longint v);
      longint m;
      m = v % ROM_DEPTH;
      if (m < 0) m = m + ROM_DEPTH;
      return int'(m);
   endfunction

   // ISA interpreter: one pc entry per clock cycle (OUT contributes two), one entry per OUT value.
   task automatic build_expect(input int ncyc);
      logic [63:0] r [16];
      logic [31:0] ins;
      logic [63:0] imm;
      int pc, op, rd, s1, s2, emitted;
      for (int i = 0; i < 16; i++) r[i] = '0;
      exp_pc.delete();
      exp_out.delete();
      pc = 0;
      emitted = 0;
      while (emitted < ncyc) begin
         exp_pc.push_back(64'(pc));
         emitted++;
         ins = fetch(pc);
         op  = int'(ins[31:28]);
         rd  = int'(ins[27:24]);
         s1  = int'(ins[23:20]);
         s2  = int'(ins[19:16]);
         imm = {{48{ins[15]}}, ins[15:0]};
         case (op)
            1:  begin r[rd] = imm;           pc = wrap(pc + 1); end
            2:  begin r[rd] = r[s1] + r[s2]; pc = wrap(pc + 1); end
            3:  begin r[rd] = r[s1] - r[s2]; pc = wrap(pc + 1); end
            4:  begin r[rd] = r[s1] & r[s2]; pc = wrap(pc + 1); end
            5:  begin r[rd] = r[s1] | r[s2]; pc = wrap(pc + 1); end
            6:  begin r[rd] = r[s1] ^ r[s2]; pc = wrap(pc + 1); end
            7:  begin r[rd] = r[s1] + imm;   pc = wrap(pc + 1); end
            8:  pc = (r[s1] == r[s2]) ? wrap(longint'(pc) + signed'(imm)) : wrap(pc + 1);
            9:  pc = (r[s1] != r[s2]) ? wrap(longint'(pc) + signed'(imm)) : wrap(pc + 1);
            10: pc = wrap(longint'(ins[15:0]));
            11: begin
               exp_out.push_back(r[s1]);
               exp_pc.push_back(64'(pc));
               emitted++;
               pc = wrap(pc + 1);
            end
            15: ;
            default: pc = wrap(pc + 1);
         endcase
         r[0] = '0;
      end
   endtask

   // Monitor: decoupled from stimulus, compares the DUT against the queues every cycle.
   logic        prev_wr;
   logic [63:0] prev_data;
   always @(negedge clk) begin
      if (!mon_en) begin
         prev_wr   = 1'b0;
         prev_data = '0;
      end else begin
         if (exp_pc.size() == 0) check("pc_trace_exhausted", 64'd1, 64'd0);
         else check("dbg_pc", dbg_pc, exp_pc.pop_front());
         if (io_write) begin
            check("low_before_strobe", 64'(prev_wr), 64'd0);
            if (exp_out.size() == 0) check("unexpected_strobe", io_data, 64'hDEAD);
            else check("io_data", io_data, exp_out.pop_front());
         end else begin
            check("io_data_hold", io_data, prev_data);
         end
         prev_wr   = io_write;
         prev_data = io_data;
      end
   end

   task automatic start_run(input int ncyc);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      @(posedge clk);
      #2;
      rst = 1'b1;
      build_expect(ncyc);
      mon_en = 1'b1;
   endtask

   task automatic full_run();
      start_run(210);
      repeat (200) @(negedge clk);
      #1;
      mon_en = 1'b0;
      check("strobes_missing", 64'(exp_out.size()), 64'd0);
      check("halt_pc", dbg_pc, 64'd9);
      check("halt_io_write", 64'(io_write), 64'd0);
      check("halt_io_data", io_data, 64'd34);
   endtask

   task automatic abort_run(input int n);
      start_run(n + 10);
      repeat (n) @(negedge clk);
      @(posedge clk);
      #($urandom_range(1, 4));
      mon_en = 1'b0;
      rst = 1'b0;
      #1;
      check("abort_pc", dbg_pc, 64'd0);
      check("abort_io_write", 64'(io_write), 64'd0);
      check("abort_io_data", io_data, 64'd0);
      repeat (2) @(negedge clk);
      check("held_reset_pc", dbg_pc, 64'd0);
   endtask

   initial begin
      rst = 1'b1;
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset_pc", dbg_pc, 64'd0);
      check("reset_io_write", 64'(io_write), 64'd0);
      check("reset_io_data", io_data, 64'd0);
      full_run();
      abort_run(25);
      for (int k = 0; k < 4; k++) abort_run(int'($urandom_range(5, 70)));
      full_run();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "simulation time limit");
   end

endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 Parameter ROM_DEPTH, default 64, number of 32-bit words in the internal instruction ROM; PC wraps modulo ROM_DEPTH.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low (asserted when 0).
REQ-004 dbg_pc  output  64  current program counter (instruction word index, zero-extended).
REQ-005 io_write  output  1  output strobe, registered, high for exactly one cycle per OUT instruction.
REQ-006 io_data  output  64  value written by the most recent OUT; held stable between OUTs.

Function
REQ-007 Architecture SHALL be single-issue, non-pipelined: one instruction per cycle from ROM[pc], except OUT which takes 2 cycles.
REQ-008 Register file SHALL be 16 x 64-bit; r0 reads 0 always, writes to r0 ignored.
REQ-009 Instruction format SHALL be [31:28] opcode, [27:24] rd, [23:20] rs1, [19:16] rs2, [15:0] imm; imm sign-extended to 64 bits.
REQ-010 Opcodes: 0 NOP; 1 LI rd=imm; 2 ADD rd=rs1+rs2; 3 SUB rd=rs1-rs2; 4 AND; 5 OR; 6 XOR; 7 ADDI rd=rs1+imm; 8 BEQ; 9 BNE; A JMP pc=imm[15:0] mod ROM_DEPTH; B OUT rs1; C-E treated as NOP; F HALT.
REQ-011 Arithmetic SHALL be 64-bit two's complement, modulo 2^64, no flags, no traps.
REQ-012 BEQ/BNE: if condition (rs1==rs2 / rs1!=rs2) holds, pc=pc+imm (word offset, mod ROM_DEPTH); else pc=pc+1.
REQ-013 Non-branch instructions SHALL set pc=pc+1 mod ROM_DEPTH.
REQ-014 OUT cycle 1: io_data<=rs1, io_write<=1; cycle 2 (stall): io_write<=0, pc<=pc+1; consecutive OUTs therefore produce separate rising edges of io_write.
REQ-015 HALT SHALL freeze pc, registers, io_data; io_write held 0; only reset leaves halt.
REQ-016 ROM SHALL be constant in RTL; addresses beyond the program hold HALT (0xF0000000).
REQ-017 ROM program (hex): 0:10000000 LI r1,0; 1:12000001 LI r2,1; 2:1300000A LI r3,10; 3:B0100000 OUT r1; 4:24120000 ADD r4,r1,r2; 5:21200000 ADD r1,r2,r0; 6:22400000 ADD r2,r4,r0; 7:7330FFFF ADDI r3,r3,-1; 8:9030FFFB BNE r3,r0,-5; 9:F0000000 HALT.
REQ-018 dbg_pc SHALL reflect the pc register directly (no latency).

Reset
REQ-019 While rst=0: pc=0, all registers=0, io_write=0, io_data=0, halt flag cleared, OUT stall state cleared, asynchronously.
REQ-020 First instruction (ROM[0]) SHALL execute on the first rising clk after rst deasserts.
REQ-021 Reset asserted mid-OUT or mid-loop SHALL abort immediately; program restarts from pc=0.

Verification
REQ-022 Release reset, run 200 cycles -> io_write rising edges deliver io_data sequence 0,1,1,2,3,5,8,13,21,34, then no further strobes.
REQ-023 Reset release -> dbg_pc=0,1,2,3 on successive cycles; io_write first high in cycle after OUT at pc=3 with io_data=0; pc=3 held for 2 cycles.
REQ-024 After program completes -> dbg_pc stays 9, io_write=0, io_data=34 indefinitely.
REQ-025 Assert rst=0 asynchronously between clock edges mid-run -> outputs immediately 0 (dbg_pc=0, io_write=0, io_data=0); on release the full Fibonacci sequence repeats from 0.
REQ-026 Each io_write pulse -> exactly 1 cycle high, followed by at least 1 cycle low; io_data unchanged while io_write low.
